text_cursor_sequencer: RTL and testbench



---
 rtl/text_cursor_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_text_cursor_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_cursor_sequencer.sv
// text_cursor_sequencer
// Takes ASCII characters over a valid/ready handshake, maps them to the 0-38
// glyph set and places each glyph at the current text cursor on a 640x480
// screen. The glyph code and its top-left pixel position are held for the
// downstream letter writer until it reports completion, or until a per-glyph
// watchdog expires. Newline, carriage return and backspace move the cursor.

module text_cursor_sequencer #(
   parameter int CELL_W  = 8,
   parameter int CELL_H  = 11,
   parameter int COLS    = 80,
   parameter int ROWS    = 43,
   parameter int TIMEOUT = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] char_code,
   input  logic       char_valid,
   output logic       char_ready,
   output logic [5:0] let_code,
   output logic [9:0] x_pos,
   output logic [8:0] y_pos,
   output logic       let_start,
   input  logic       let_done,
   output logic       busy,
   output logic       timeout_err
);

   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [5:0] GLYPH_SPACE   = 6'd36;
   localparam logic [5:0] GLYPH_PERIOD  = 6'd37;
   localparam logic [5:0] GLYPH_UNKNOWN = 6'd38;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_ISSUE,
      S_WAIT_LOW,
      S_WAIT_HIGH,
      S_ADVANCE
   } state_t;

   typedef enum logic [2:0] {
      C_PRINT,
      C_NEWLINE,
      C_RETURN,
      C_BACKSPACE,
      C_DROP
   } char_class_t;

   state_t           state;
   logic [7:0]       char_reg;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [CNT_W-1:0] tmo_cnt;
   logic             is_bs;

   char_class_t      char_class;
   logic [ROW_W-1:0] row_inc;
   logic [COL_W-1:0] bs_col;
   logic [ROW_W-1:0] bs_row;
   logic [COL_W-1:0] adv_col;
   logic [ROW_W-1:0] adv_row;

   // Sort a character into the handful of behaviours the sequencer knows.
   function automatic char_class_t classify(input logic [7:0] c);
      char_class_t k;
      k = C_DROP;
      if (c == 8'h0A)
         k = C_NEWLINE;
      else if (c == 8'h0D)
         k = C_RETURN;
      else if (c == 8'h08)
         k = C_BACKSPACE;
      else if (c >= 8'h20 && c <= 8'h7E)
         k = C_PRINT;
      return k;
   endfunction

   // Letters are case-folded onto 0-25, digits follow at 26-35.
   function automatic logic [5:0] glyph_of(input logic [7:0] c);
      logic [5:0] g;
      g = GLYPH_UNKNOWN;
      if (c >= 8'h41 && c <= 8'h5A)
         g = 6'(c - 8'h41);
      else if (c >= 8'h61 && c <= 8'h7A)
         g = 6'(c - 8'h61);
      else if (c >= 8'h30 && c <= 8'h39)
         g = 6'(c - 8'h30 + 8'd26);
      else if (c == 8'h20)
         g = GLYPH_SPACE;
      else if (c == 8'h2E)
         g = GLYPH_PERIOD;
      return g;
   endfunction

   // Pixel position of a cell's top-left corner (constant multiplies).
   function automatic logic [9:0] x_of(input logic [COL_W-1:0] c);
      return 10'(int'(c) * CELL_W);
   endfunction

   function automatic logic [8:0] y_of(input logic [ROW_W-1:0] r);
      return 9'(int'(r) * CELL_H);
   endfunction

   // Candidate cursor positions for newline, backspace and glyph advance.
   always_comb begin
      char_class = classify(char_reg);

      row_inc = (row == ROW_LAST) ? '0 : row + 1'b1;

      bs_col = col;
      bs_row = row;
      if (col != '0) begin
         bs_col = col - 1'b1;
      end else if (row != '0) begin
         bs_col = COL_LAST;
         bs_row = row - 1'b1;
      end

      adv_col = col + 1'b1;
      adv_row = row;
      if (col == COL_LAST) begin
         adv_col = '0;
         adv_row = row_inc;
      end
   end

   // Sequencer FSM: handshake, cursor tracking, glyph issue and writer watchdog.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         char_reg    <= '0;
         col         <= '0;
         row         <= '0;
         tmo_cnt     <= '0;
         is_bs       <= 1'b0;
         char_ready  <= 1'b0;
         let_code    <= '0;
         x_pos       <= '0;
         y_pos       <= '0;
         let_start   <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         let_start <= 1'b0;

         case (state)
            S_IDLE: begin
               if (char_valid && char_ready) begin
                  char_reg   <= char_code;
                  char_ready <= 1'b0;
                  busy       <= 1'b1;
                  state      <= S_DECODE;
               end else begin
                  char_ready <= 1'b1;
               end
            end

            S_DECODE: begin
               case (char_class)
                  C_NEWLINE: begin
                     col        <= '0;
                     row        <= row_inc;
                     char_ready <= 1'b1;
                     busy       <= 1'b0;
                     state      <= S_IDLE;
                  end
                  C_RETURN: begin
                     col        <= '0;
                     char_ready <= 1'b1;
                     busy       <= 1'b0;
                     state      <= S_IDLE;
                  end
                  C_BACKSPACE: begin
                     // Erase by painting a space over the previous cell; the
                     // cursor then stays on that cell.
                     col       <= bs_col;
                     row       <= bs_row;
                     let_code  <= GLYPH_SPACE;
                     x_pos     <= x_of(bs_col);
                     y_pos     <= y_of(bs_row);
                     let_start <= 1'b1;
                     is_bs     <= 1'b1;
                     state     <= S_ISSUE;
                  end
                  C_PRINT: begin
                     let_code  <= glyph_of(char_reg);
                     x_pos     <= x_of(col);
                     y_pos     <= y_of(row);
                     let_start <= 1'b1;
                     is_bs     <= 1'b0;
                     state     <= S_ISSUE;
                  end
                  default: begin
                     char_ready <= 1'b1;
                     busy       <= 1'b0;
                     state      <= S_IDLE;
                  end
               endcase
            end

            S_ISSUE: begin
               // let_start is high for exactly this cycle.
               tmo_cnt <= '0;
               state   <= S_WAIT_LOW;
            end

            S_WAIT_LOW: begin
               // A done level left over from the previous glyph must drop
               // before a rising done can mean this glyph finished.
               if (tmo_cnt == CNT_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= S_ADVANCE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  if (!let_done)
                     state <= S_WAIT_HIGH;
               end
            end

            S_WAIT_HIGH: begin
               if (tmo_cnt == CNT_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= S_ADVANCE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  if (let_done)
                     state <= S_ADVANCE;
               end
            end

            S_ADVANCE: begin
               if (!is_bs) begin
                  col <= adv_col;
                  row <= adv_row;
               end
               char_ready <= 1'b1;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end

            default: begin
               char_ready <= 1'b0;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_cursor_sequencer.sv
// Directed bench for text_cursor_sequencer: a cursor model pushes the expected
// glyph/position for every character sent, and a monitor pops and compares on
// each let_start pulse. A small writer model answers let_done.

module tb_text_cursor_sequencer;

   logic       clk;
   logic       rst_n;
   logic [7:0] char_code;
   logic       char_valid;
   logic       char_ready;
   logic [5:0] let_code;
   logic [9:0] x_pos;
   logic [8:0] y_pos;
   logic       let_start;
   logic       let_done;
   logic       busy;
   logic       timeout_err;

   typedef struct packed {
      logic [5:0] g;
      logic [9:0] x;
      logic [8:0] y;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int m_col    = 0;
   int m_row    = 0;

   // writer behaviour: 0 = drop done on start, raise after wr_delay cycles;
   // 1 = done stuck high; 2 = done stuck low
   int wr_mode  = 0;
   int wr_delay = 2;
   int wr_cnt   = 0;

   text_cursor_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .char_code   (char_code),
      .char_valid  (char_valid),
      .char_ready  (char_ready),
      .let_code    (let_code),
      .x_pos       (x_pos),
      .y_pos       (y_pos),
      .let_start   (let_start),
      .let_done    (let_done),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic logic [5:0] model_glyph(input logic [7:0] c);
      if (c inside {[8'h41:8'h5A]}) return 6'(c - 8'h41);
      if (c inside {[8'h61:8'h7A]}) return 6'(c - 8'h61);
      if (c inside {[8'h30:8'h39]}) return 6'(c - 8'h30 + 8'd26);
      if (c == 8'h20) return 6'd36;
      if (c == 8'h2E) return 6'd37;
      return 6'd38;
   endfunction

   task automatic push_exp(input logic [5:0] g);
      exp_t e;
      e.g = g;
      e.x = 10'(m_col * 8);
      e.y = 9'(m_row * 11);
      exp_q.push_back(e);
   endtask

   // Reference cursor behaviour on a 80x43 grid.
   task automatic model_char(input logic [7:0] c);
      if (c == 8'h0A) begin
         m_col = 0;
         m_row = (m_row == 42) ? 0 : m_row + 1;
      end else if (c == 8'h0D) begin
         m_col = 0;
      end else if (c == 8'h08) begin
         if (m_col > 0) begin
            m_col--;
         end else if (m_row > 0) begin
            m_col = 79;
            m_row--;
         end
         push_exp(6'd36);
      end else if (c >= 8'h20 && c <= 8'h7E) begin
         push_exp(model_glyph(c));
         if (m_col == 79) begin
            m_col = 0;
            m_row = (m_row == 42) ? 0 : m_row + 1;
         end else begin
            m_col++;
         end
      end
   endtask

   // Returns at the falling edge right after the accepting rising edge.
   task automatic send(input logic [7:0] c);
      int t;
      t = 0;
      @(negedge clk);
      while (char_ready !== 1'b1 && t < 6000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 6000) check("send_ready_wait", char_ready, 1);
      model_char(c);
      char_code  = c;
      char_valid = 1'b1;
      @(negedge clk);
      char_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int t;
      t = 0;
      while (char_ready !== 1'b1 && t < 6000) begin
         @(negedge clk);
         t++;
      end
      check("ready_back", char_ready, 1);
   endtask

   task automatic do_reset();
      check("queue_drained", exp_q.size(), 0);
      char_valid = 1'b0;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_char_ready", char_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_let_start", let_start, 0);
      check("rst_timeout_err", timeout_err, 0);
      check("rst_x_pos", x_pos, 0);
      exp_q.delete();
      m_col = 0;
      m_row = 0;
      rst_n = 1'b1;
   endtask

   // Writer model, driven away from the active edge.
   always @(negedge clk) begin
      if (wr_mode == 1) begin
         let_done = 1'b1;
      end else if (wr_mode == 2) begin
         let_done = 1'b0;
      end else if (let_start === 1'b1) begin
         let_done = 1'b0;
         wr_cnt   = wr_delay;
      end else if (wr_cnt > 0) begin
         wr_cnt--;
         if (wr_cnt == 0) let_done = 1'b1;
      end
   end

   // Scoreboard: every let_start must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && let_start === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_let_start", exp_q.size(), 1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("let_code", let_code, e.g);
            check("x_pos", x_pos, e.x);
            check("y_pos", y_pos, e.y);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      char_code  = 8'h00;
      char_valid = 1'b0;
      let_done   = 1'b1;

      // 1: single 'A' with a slow writer, exact issue latency
      do_reset();
      wr_delay = 20;
      send(8'h41);
      check("t1_start_not_yet", let_start, 0);
      check("t1_busy", busy, 1);
      check("t1_ready_low", char_ready, 0);
      @(negedge clk);
      check("t1_start_pulse", let_start, 1);
      @(negedge clk);
      check("t1_start_one_cycle", let_start, 0);
      wait_ready();
      check("t1_busy_idle", busy, 0);
      wr_delay = 2;
      send(8'h43);
      wait_ready();

      // 2: fill a full row, wrap to the next; misc codes
      do_reset();
      for (int i = 0; i < 80; i++) send(8'h37);
      send(8'h42);
      send(8'h01);
      send(8'h23);
      send(8'h0D);
      send(8'h7E);
      send(8'h7F);
      send(8'h35);
      wait_ready();

      // 3: newline on the last row wraps to the top
      do_reset();
      for (int i = 0; i < 42; i++) send(8'h0A);
      for (int i = 0; i < 5; i++) send(8'h78);
      send(8'h0A);
      send(8'h2E);
      wait_ready();

      // 4: backspace from column 0 steps back to the previous row end
      do_reset();
      for (int i = 0; i < 3; i++) send(8'h0A);
      send(8'h08);
      send(8'h61);
      send(8'h08);
      send(8'h08);
      send(8'h20);
      wait_ready();

      // 5: writer done stuck high -> watchdog
      do_reset();
      wr_mode = 1;
      send(8'h7A);
      @(negedge clk);
      repeat (4000) @(negedge clk);
      check("t5_no_early_timeout", timeout_err, 0);
      check("t5_still_busy", busy, 1);
      wait_ready();
      check("t5_timeout_err", timeout_err, 1);

      // 6: reset in the middle of WAIT_HIGH
      wr_mode = 0;
      send(8'h0A);
      send(8'h72);
      wait_ready();
      wr_mode = 2;
      send(8'h71);
      repeat (5) @(negedge clk);
      check("t6_busy_before", busy, 1);
      check("t6_x_held", x_pos, 8);
      check("t6_y_held", y_pos, 11);
      check("t6_err_sticky", timeout_err, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_let_code", let_code, 0);
      check("t6_x_pos", x_pos, 0);
      check("t6_y_pos", y_pos, 0);
      check("t6_busy", busy, 0);
      check("t6_let_start", let_start, 0);
      check("t6_timeout_err", timeout_err, 0);
      check("t6_char_ready", char_ready, 0);
      check("t6_queue_drained", exp_q.size(), 0);
      @(negedge clk);
      m_col   = 0;
      m_row   = 0;
      wr_mode = 0;
      rst_n   = 1'b1;
      send(8'h4B);
      wait_ready();
      check("t6_err_stays_clear", timeout_err, 0);

      check("final_queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
